// File: rtl/vga_timing_if.sv
// Raster bus between the VGA timing generator and its pixel-pipeline consumers.
// With VGA_LINE_IRQ_EN defined the bus also carries line_cmp / line_irq.
interface vga_timing_if #(
  parameter int CX = 10,
  parameter int CY = 10
);
  logic          en;
  logic [CX-1:0] h_count;
  logic [CY-1:0] v_count;
  logic          hsync;
  logic          vsync;
  logic          active;
  logic          line_start;
  logic          frame_start;
`ifdef VGA_LINE_IRQ_EN
  logic [CY-1:0] line_cmp;
  logic          line_irq;

  modport master (
    input  en, line_cmp,
    output h_count, v_count, hsync, vsync, active, line_start, frame_start, line_irq
  );

  modport slave (
    output en, line_cmp,
    input  h_count, v_count, hsync, vsync, active, line_start, frame_start, line_irq
  );
`else
  modport master (
    input  en,
    output h_count, v_count, hsync, vsync, active, line_start, frame_start
  );

  modport slave (
    output en,
    input  h_count, v_count, hsync, vsync, active, line_start, frame_start
  );
`endif
endinterface

// File: rtl/vga_timing.sv
// Parametrised VGA raster timing generator; counters and all flags share one register stage.
// Optional feature: define VGA_LINE_IRQ_EN to add the line-compare interrupt (line_cmp / line_irq).
module vga_timing #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CX       = 10,
  parameter int CY       = 10
) (
  input logic          clk,
  input logic          rst,
  vga_timing_if.master vif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CX-1:0] H_LAST   = CX'(H_TOTAL - 1);
  localparam logic [CX-1:0] H_VIS    = CX'(H_ACTIVE);
  localparam logic [CX-1:0] HS_FIRST = CX'(H_ACTIVE + H_FP);
  localparam logic [CX-1:0] HS_LAST  = CX'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CY-1:0] V_LAST   = CY'(V_TOTAL - 1);
  localparam logic [CY-1:0] V_VIS    = CY'(V_ACTIVE);
  localparam logic [CY-1:0] VS_FIRST = CY'(V_ACTIVE + V_FP);
  localparam logic [CY-1:0] VS_LAST  = CY'(V_ACTIVE + V_FP + V_SYNC - 1);

  // A mode that does not fit the counter widths would silently alias lines/columns.
  if (longint'(H_TOTAL) > (longint'(1) << CX)) begin : g_cx_too_small
    $error("vga_timing: H_TOTAL does not fit in CX bits");
  end
  if (longint'(V_TOTAL) > (longint'(1) << CY)) begin : g_cy_too_small
    $error("vga_timing: V_TOTAL does not fit in CY bits");
  end

  function automatic logic hs_level(input logic [CX-1:0] h);
    return ((h >= HS_FIRST) && (h <= HS_LAST)) ? HS_POL : ~HS_POL;
  endfunction

  function automatic logic vs_level(input logic [CY-1:0] v);
    return ((v >= VS_FIRST) && (v <= VS_LAST)) ? VS_POL : ~VS_POL;
  endfunction

  function automatic logic is_active(input logic [CX-1:0] h, input logic [CY-1:0] v);
    return (h < H_VIS) && (v < V_VIS);
  endfunction

  logic          h_wrap;
  logic [CX-1:0] h_nxt;
  logic [CY-1:0] v_nxt;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    h_wrap = (vif.h_count == H_LAST);
    h_nxt  = h_wrap ? '0 : vif.h_count + CX'(1);
    v_nxt  = vif.v_count;
    if (h_wrap) begin
      v_nxt = (vif.v_count == V_LAST) ? '0 : vif.v_count + CY'(1);
    end
  end

  // Flags are decoded from the next counts so they land in the same cycle as the counters.
  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vif.h_count     <= '0;
      vif.v_count     <= '0;
      vif.hsync       <= hs_level('0);
      vif.vsync       <= vs_level('0);
      vif.active      <= is_active('0, '0);
      vif.line_start  <= 1'b1;
      vif.frame_start <= 1'b1;
    end else if (vif.en) begin
      vif.h_count     <= h_nxt;
      vif.v_count     <= v_nxt;
      vif.hsync       <= hs_level(h_nxt);
      vif.vsync       <= vs_level(v_nxt);
      vif.active      <= is_active(h_nxt, v_nxt);
      vif.line_start  <= (h_nxt == '0);
      vif.frame_start <= (h_nxt == '0) && (v_nxt == '0);
    end
  end

`ifdef VGA_LINE_IRQ_EN
  // line_cmp is only looked at on the h wrap; values >= V_TOTAL never match v_nxt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vif.line_irq <= 1'b0;
    end else if (vif.en) begin
      vif.line_irq <= h_wrap && (v_nxt == vif.line_cmp);
    end
  end
`endif

endmodule

// File: doc/vga_timing.md
# vga_timing

Parametrised VGA raster timing generator: produces horizontal/vertical pixel counters plus registered sync, active-video and frame/line markers for any mode given by porch/sync/active parameters. Sits between the pixel-clock domain root and the pixel pipeline (pattern/framebuffer readers), which consume `h_count`/`v_count` and `active`. Advances only on a pixel-enable so one fast clock can drive modes at divided pixel rates.

## Interface
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, hsync width (pixels)
- `H_BP`, 48, horizontal back porch (pixels)
- `V_ACTIVE`, 480, visible lines per frame
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vsync width (lines)
- `V_BP`, 33, vertical back porch (lines)
- `HS_POL`, 0, hsync asserted level (0 = active-low)
- `VS_POL`, 0, vsync asserted level (0 = active-low)
- `CX`, 10, h_count width; must hold H_TOTAL-1
- `CY`, 10, v_count width; must hold V_TOTAL-1
- `clk`  in  1  pixel-domain clock
- `rst`  in  1  asynchronous, active-high reset
- `en`  in  1  pixel enable; state advances only when high
- `h_count`  out  CX  current pixel column, 0..H_TOTAL-1
- `v_count`  out  CY  current line, 0..V_TOTAL-1
- `hsync`  out  1  horizontal sync at HS_POL level when asserted
- `vsync`  out  1  vertical sync at VS_POL level when asserted
- `active`  out  1  high when h_count < H_ACTIVE and v_count < V_ACTIVE
- `line_start`  out  1  high for the en-cycle where h_count == 0
- `frame_start`  out  1  high for the en-cycle where h_count == 0 and v_count == 0

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
- On `en`: h_count increments; at H_TOTAL-1 wraps to 0 and v_count increments; v_count at V_TOTAL-1 wraps to 0 on that same h wrap. No off-by-one: exactly H_TOTAL columns, V_TOTAL lines.
- `en` low: all outputs hold (no count, pulses held too, not cleared).
- hsync asserted for h_count in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]; vsync asserted for v_count in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], whole lines (changes at h wrap).
- All outputs are flops, decoded from the next-count values, so every flag is consistent with `h_count`/`v_count` in the same cycle.
- Width rule: compares done at CX/CY width; parameters violating H_TOTAL ≤ 2^CX or V_TOTAL ≤ 2^CY are a static error (elaboration assertion).

## Timing
- Reset (async assert, sync release on `clk`): h_count=0, v_count=0, hsync=!HS_POL, vsync=!VS_POL, active=1, line_start=1, frame_start=1 (reset state is the first pixel of frame).
- First `en` after reset moves to (1,0); line_start/frame_start drop.
- Latency 0 between counters and flags (same register stage).
- Reset mid-frame: immediate return to reset values regardless of `en`.
- Sustained `en`=1: one frame = H_TOTAL*V_TOTAL clocks, frame_start period identical.

## Configuration
- `VGA_LINE_IRQ_EN` defined: adds input `line_cmp` [CY-1:0] and output `line_irq` (1 bit, registered, reset 0); `line_irq` high for exactly the en-cycle where h_count == 0 and v_count == line_cmp; `line_cmp` sampled at the h wrap. line_cmp ≥ V_TOTAL never fires.
- Not defined: neither port exists; no extra logic.

## Test plan
Small mode H 8/2/3/3 (H_TOTAL 16), V 4/1/2/1 (V_TOTAL 8), CX=CY=4, polarities 0.
- Reset then `en`=1 for 128 clocks -> h_count 0..15 wrap, v_count 0..7, frame_start high at clocks 0 and 128 only.
- Same run -> hsync low exactly at h_count 10..12, vsync low for all of v_count 5..6, active high only h<8 and v<4 (32 clocks per frame).
- `en` toggled 1/0 each clock -> frame period 256 clocks, outputs frozen on `en`=0 cycles.
- Assert `rst` at (h=6,v=3) for 1 clock mid-cycle -> outputs return to (0,0), frame_start=1 asynchronously; resume cleanly.
- HS_POL=VS_POL=1 -> sync levels inverted, all timing unchanged.
- `VGA_LINE_IRQ_EN`, line_cmp=3 -> line_irq single pulse at (h=0,v=3) each frame; line_cmp=9 -> never fires.
